// File: rtl/ram_bram_responder.sv
// BRAM-backed stand-in for the DDR2 bridge on the async-SRAM-style RAM pins.
// Reproduces the bridge's fixed read/write latency and adds sticky status flags.
module ram_bram_responder #(
  parameter int ADDR_W    = 27,
  parameter int DEPTH_W   = 14,
  parameter int READ_LAT  = 8,
  parameter int WRITE_LAT = 8
) (
  input  logic              clk_100MHz,
  input  logic              rstn,
  input  logic [ADDR_W-1:0] ram_a,
  input  logic [15:0]       ram_dq_i,
  output logic [15:0]       ram_dq_o,
  input  logic              ram_cen,
  input  logic              ram_oen,
  input  logic              ram_wen,
  input  logic              ram_ub,
  input  logic              ram_lb,
  output logic              busy,
  output logic              rd_valid,
  output logic              addr_oob,
  output logic              overrun
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] WR_WAIT = 2'd1;
  localparam logic [1:0] RD_WAIT = 2'd2;

  localparam logic [7:0] WR_LOAD = 8'(WRITE_LAT - 1);
  localparam logic [7:0] RD_LOAD = 8'(READ_LAT - 1);

  logic               cen_q;
  logic [1:0]         state_q, state_d;
  logic [7:0]         cnt_q, cnt_d;
  logic [DEPTH_W-1:0] addr_q, addr_d;
  logic [15:0]        wdata_q, wdata_d;
  logic               ub_q, ub_d;
  logic               lb_q, lb_d;
  logic [15:0]        dq_q, dq_d;
  logic               rd_valid_q, rd_valid_d;
  logic               oob_q, oob_d;
  logic               overrun_q, overrun_d;
  logic [15:0]        rd_data_q;
  logic               start;
  logic               wr_en;
  logic               rd_en;

  logic [15:0] mem [0:(2**DEPTH_W)-1];

  // A start is the registered cen seen high while the pin is now low.
  assign start = cen_q & ~ram_cen;
  assign wr_en = (state_q == WR_WAIT) && (cnt_q == 8'd0);
  // The array read is issued one cycle early so the output load fits the budget.
  assign rd_en = (state_q == RD_WAIT) && (cnt_q == 8'd1);

  always_comb begin
    // NOTE: every next-state variable gets a default here so no path infers a latch.
    state_d    = state_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    ub_d       = ub_q;
    lb_d       = lb_q;
    dq_d       = dq_q;
    rd_valid_d = 1'b0;
    oob_d      = oob_q;
    overrun_d  = overrun_q;

    case (state_q)
      IDLE: begin
        if (start && (!ram_wen || !ram_oen)) begin
          addr_d  = ram_a[DEPTH_W-1:0];
          wdata_d = ram_dq_i;
          ub_d    = ram_ub;
          lb_d    = ram_lb;
          if (|ram_a[ADDR_W-1:DEPTH_W]) oob_d = 1'b1;
          if (!ram_wen) begin
            state_d = WR_WAIT;
            cnt_d   = WR_LOAD;
          end else begin
            state_d = RD_WAIT;
            cnt_d   = RD_LOAD;
          end
        end
      end
      WR_WAIT: begin
        if (cnt_q == 8'd0) state_d = IDLE;
        else               cnt_d   = cnt_q - 8'd1;
      end
      RD_WAIT: begin
        if (cnt_q == 8'd0) begin
          state_d    = IDLE;
          dq_d       = {ub_q ? 8'h00 : rd_data_q[15:8], lb_q ? 8'h00 : rd_data_q[7:0]};
          rd_valid_d = 1'b1;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (start && (state_q != IDLE)) overrun_d = 1'b1;
  end

  always_ff @(posedge clk_100MHz or negedge rstn) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (!rstn) begin
      cen_q      <= 1'b1;
      state_q    <= IDLE;
      cnt_q      <= 8'd0;
      addr_q     <= '0;
      wdata_q    <= 16'h0000;
      ub_q       <= 1'b1;
      lb_q       <= 1'b1;
      dq_q       <= 16'h0000;
      rd_valid_q <= 1'b0;
      oob_q      <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      cen_q      <= ram_cen;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      ub_q       <= ub_d;
      lb_q       <= lb_d;
      dq_q       <= dq_d;
      rd_valid_q <= rd_valid_d;
      oob_q      <= oob_d;
      overrun_q  <= overrun_d;
    end
  end

  // NOTE: the array and its read register carry no reset so they map onto block RAM;
  // a reset mid-write is safe because wr_en depends on the reset-cleared FSM state.
  always_ff @(posedge clk_100MHz) begin
    if (wr_en) begin
      if (!ub_q) mem[addr_q][15:8] <= wdata_q[15:8];
      if (!lb_q) mem[addr_q][7:0]  <= wdata_q[7:0];
    end
    if (rd_en) rd_data_q <= mem[addr_q];
  end

  assign ram_dq_o = dq_q;
  assign busy     = (state_q != IDLE);
  assign rd_valid = rd_valid_q;
  assign addr_oob = oob_q;
  assign overrun  = overrun_q;

endmodule

// File: doc/ram_bram_responder.md
Name: ram_bram_responder

Overview:
- BRAM-backed responder for the async-SRAM-style RAM interface (ram_a/ram_dq_i/ram_dq_o/ram_cen/ram_oen/ram_wen/ram_ub/ram_lb).
- Pin-compatible drop-in for the DDR2 bridge on the RAM side. Lets the memory controller and the record/playback path run in simulation and board bring-up without the DDR2 part.
- Models the bridge's fixed access latency and adds status flags for verification.

Parameters:
- ADDR_W, 27, width of ram_a (matches the existing RAM address bus).
- DEPTH_W, 14, log2 of the number of internal 16-bit words (16384).
- READ_LAT, 8, cycles from accepted read to ram_dq_o valid; legal range 2..255.
- WRITE_LAT, 8, cycles from accepted write to array update and busy release; legal range 2..255.

Ports:
- clk_100MHz  in  1  system clock; all logic on the rising edge.
- rstn  in  1  asynchronous active-low reset.
- ram_a  in  ADDR_W  word address.
- ram_dq_i  in  16  write data.
- ram_dq_o  out  16  read data; holds the last completed read.
- ram_cen  in  1  chip enable, active low.
- ram_oen  in  1  output enable, active low.
- ram_wen  in  1  write enable, active low.
- ram_ub  in  1  upper byte lane [15:8] enable, active low.
- ram_lb  in  1  lower byte lane [7:0] enable, active low.
- busy  out  1  access in progress.
- rd_valid  out  1  one-cycle pulse when ram_dq_o is updated.
- addr_oob  out  1  sticky: an accepted address had nonzero bits above DEPTH_W-1.
- overrun  out  1  sticky: ram_cen fell while busy.

Behaviour:
- Reset: async assert on rstn low; sync release.
  - ram_dq_o=0, busy=0, rd_valid=0, addr_oob=0, overrun=0, FSM=IDLE, counter=0.
  - Array contents are not cleared.
- Input registering: ram_cen is registered once. An access start is a registered cen transition from 1 to 0 (falling edge).
  - In the same cycle as the start, latch ram_a[DEPTH_W-1:0], ram_dq_i, ram_wen, ram_oen, ram_ub and ram_lb.
  - All later pin changes are ignored until the access completes.
- Decode of the latched strobes:
  - wen=0 → WRITE. This takes priority over oen=0.
  - wen=1 and oen=0 → READ.
  - wen=1 and oen=1 → no-op. busy is not asserted and no flags change.
- FSM states: IDLE, WR_WAIT, RD_WAIT.
  - IDLE → WR_WAIT or RD_WAIT on an accepted start. busy rises the cycle after the start cycle. The counter loads the matching latency minus 1.
  - WR_WAIT: decrement the counter. At 0, write enabled lanes to the array and return to IDLE. busy drops the following cycle.
  - RD_WAIT: decrement the counter. At 0, load ram_dq_o from the array. For a disabled lane (ub/lb=1) load that byte as 0. Pulse rd_valid for one cycle and return to IDLE.
  - Total latency from the start-cycle edge to ram_dq_o valid is exactly READ_LAT cycles. The array is registered-read with one cycle of that budget.
- Byte lanes on write: ub=0 writes [15:8], lb=0 writes [7:0]. If both are 1, the write still takes WRITE_LAT cycles but the array is unchanged.
- Out-of-range address: if ram_a[ADDR_W-1:DEPTH_W] != 0, set addr_oob and perform the access at the wrapped low bits.
- Start while busy: set overrun. The new request is dropped and the in-flight access completes unchanged.
- cen rising mid-access does not abort; the latched operation completes.
- Back-to-back: a new start is accepted the cycle after the FSM returns to IDLE, i.e. the registered cen must show 1 then 0 again.
- Reset mid-access: the access is abandoned and an in-flight write is not committed. Outputs go to reset values.
- Sticky flags clear only on reset.
- Width rules: the counter is 8 bits. The address index is DEPTH_W bits. No arithmetic on data.

Test Plan:
- Write/read round trip: write 16'hA5C3 to address 666 (ub=lb=0) → busy for WRITE_LAT cycles. Then read 666 → ram_dq_o=16'hA5C3 exactly 8 cycles after the start edge, with a single rd_valid pulse.
- Byte lanes: preload 16'h1234 at address 5, then write 16'hABCD with ub=0, lb=1 → a read returns 16'hAB34. A read with ub=1, lb=0 returns 16'h0034.
- Priority/no-op: a start with wen=0 and oen=0 writes (no rd_valid). A start with wen=1 and oen=1 → busy stays 0 and the array is unchanged.
- Out-of-range: write 16'h7FFF to address 16384+3 → addr_oob=1, and a read of address 3 returns 16'h7FFF.
- Overrun: a second cen falling edge 3 cycles into a read → overrun=1, the first read completes with correct data, and the second request is never serviced.
- Reset mid-write: drop rstn 4 cycles into a write of 16'hFFFF at address 9 (previously 16'h0001) → outputs are zero. After release, a read of address 9 returns 16'h0001.
